// File: rtl/ieee_to_fixed.sv
// Converts an IEEE-754 single to unsigned Q5.5 magnitude plus sign and status flags.
// Denormalisation is a serial right shift of the significand, one bit per clock.
module ieee_to_fixed (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] fin,
  output logic        busy,
  output logic        done,
  output logic [4:0]  int_part,
  output logic [4:0]  frac_part,
  output logic        neg,
  output logic        ovf,
  output logic        nan,
  output logic        inexact
);

  typedef enum logic [1:0] {StIdle, StCheck, StShift, StDone} state_e;

  state_e      state_q, state_d;
  logic [31:0] fin_q, fin_d;
  logic [23:0] shreg_q, shreg_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        sticky_q, sticky_d;

  // Pending result, copied to the output registers in StDone.
  logic [9:0]  res_q, res_d;
  logic        pneg_q, pneg_d, povf_q, povf_d, pnan_q, pnan_d, pinx_q, pinx_d;

  logic [9:0]  out_q, out_d;
  logic        neg_q, neg_d, ovf_q, ovf_d, nan_q, nan_d, inx_q, inx_d;
  logic        done_q, done_d;

  logic [7:0]  exp_w;
  logic [22:0] man_w;

  assign exp_w = fin_q[30:23];
  assign man_w = fin_q[22:0];

  always_comb begin
    state_d  = state_q;
    fin_d    = fin_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    res_d    = res_q;
    pneg_d   = pneg_q;
    povf_d   = povf_q;
    pnan_d   = pnan_q;
    pinx_d   = pinx_q;
    out_d    = out_q;
    neg_d    = neg_q;
    ovf_d    = ovf_q;
    nan_d    = nan_q;
    inx_d    = inx_q;
    done_d   = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          fin_d   = fin;
          state_d = StCheck;
        end
      end
      StCheck: begin
        state_d = StDone;
        res_d   = 10'd0;
        pneg_d  = fin_q[31];
        povf_d  = 1'b0;
        pnan_d  = 1'b0;
        pinx_d  = 1'b0;
        if (exp_w == 8'd255 && man_w != 23'd0) begin
          pnan_d = 1'b1;
          pneg_d = 1'b0;
        end else if (exp_w == 8'd255) begin
          res_d  = 10'h3FF;
          povf_d = 1'b1;
        end else if (exp_w == 8'd0) begin
          pinx_d = |man_w;
        end else if (exp_w > 8'd131) begin
          res_d  = 10'h3FF;
          povf_d = 1'b1;
        end else if (exp_w < 8'd122) begin
          pinx_d = 1'b1;
        end else begin
          // Shift count that lands the 1/32 weight on bit 0: 145 - e, range 14..23.
          shreg_d  = {1'b1, man_w};
          cnt_d    = 5'(8'd145 - exp_w);
          sticky_d = 1'b0;
          state_d  = StShift;
        end
      end
      StShift: begin
        shreg_d  = shreg_q >> 1;
        sticky_d = sticky_q | shreg_q[0];
        cnt_d    = cnt_q - 5'd1;
        res_d    = shreg_d[9:0];
        pinx_d   = sticky_d;
        if (cnt_q == 5'd1) state_d = StDone;
      end
      StDone: begin
        out_d   = res_q;
        neg_d   = pneg_q;
        ovf_d   = povf_q;
        nan_d   = pnan_q;
        inx_d   = pinx_q;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      fin_q    <= 32'd0;
      shreg_q  <= 24'd0;
      cnt_q    <= 5'd0;
      sticky_q <= 1'b0;
      res_q    <= 10'd0;
      pneg_q   <= 1'b0;
      povf_q   <= 1'b0;
      pnan_q   <= 1'b0;
      pinx_q   <= 1'b0;
      out_q    <= 10'd0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
      nan_q    <= 1'b0;
      inx_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      fin_q    <= fin_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
      res_q    <= res_d;
      pneg_q   <= pneg_d;
      povf_q   <= povf_d;
      pnan_q   <= pnan_d;
      pinx_q   <= pinx_d;
      out_q    <= out_d;
      neg_q    <= neg_d;
      ovf_q    <= ovf_d;
      nan_q    <= nan_d;
      inx_q    <= inx_d;
      done_q   <= done_d;
    end
  end

  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign int_part  = out_q[9:5];
  assign frac_part = out_q[4:0];
  assign neg       = neg_q;
  assign ovf       = ovf_q;
  assign nan       = nan_q;
  assign inexact   = inx_q;

endmodule

// File: tb/tb_ieee_to_fixed.sv
// Directed bench for ieee_to_fixed: latency, results, flags, handshake and async reset.
module tb_ieee_to_fixed;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] fin = 32'd0;
  logic        busy, done, neg, ovf, nan, inexact;
  logic [4:0]  int_part, frac_part;

  int tests = 0;
  int fails = 0;

  ieee_to_fixed dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .fin      (fin),
    .busy     (busy),
    .done     (done),
    .int_part (int_part),
    .frac_part(frac_part),
    .neg      (neg),
    .ovf      (ovf),
    .nan      (nan),
    .inexact  (inexact)
  );

  always #5 clk = ~clk;

  // Packs {latency, int, frac, neg, ovf, nan, inexact} into one 22-bit word.
  function automatic logic [21:0] pack(input int lat, input int ip, input int fp,
                                       input bit s, input bit o, input bit n, input bit x);
    logic [7:0] l8;
    logic [4:0] i5, f5;
    l8 = 8'(lat);
    i5 = 5'(ip);
    f5 = 5'(fp);
    return {l8, i5, f5, s, o, n, x};
  endfunction

  // Issues one conversion and returns the observed latency and outputs at done.
  task automatic run_conv(input logic [31:0] f, output logic [21:0] obs);
    int lat;
    lat = 0;
    @(negedge clk);
    fin   = f;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    fin   = 32'hDEADBEEF;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!done && lat < 40);
    obs = pack(lat, int_part, frac_part, neg, ovf, nan, inexact);
  endtask

  task automatic test_reset;
    logic [21:0] obs;
    #2;
    obs = pack(0, int_part, frac_part, neg, ovf, nan, inexact);
    tests++;
    if (obs !== 22'd0 || busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: got %h busy=%b done=%b, want 0", obs, busy, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_normal;
    logic [21:0] obs, exp;
    logic [31:0] vecs [3];
    logic [21:0] exps [3];
    vecs[0] = 32'h40D80000; exps[0] = pack(18, 6, 24, 0, 0, 0, 0);
    vecs[1] = 32'hC0D80000; exps[1] = pack(18, 6, 24, 1, 0, 0, 0);
    vecs[2] = 32'h3F800001; exps[2] = pack(20, 1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      run_conv(vecs[i], obs);
      exp = exps[i];
      tests++;
      if (obs !== exp) begin
        fails++;
        $display("FAIL normal[%0h]: got %h want %h", vecs[i], obs, exp);
      end
    end
  endtask

  task automatic test_special;
    logic [21:0] obs;
    logic [31:0] vecs [4];
    logic [21:0] exps [4];
    vecs[0] = 32'h42000000; exps[0] = pack(2, 31, 31, 0, 1, 0, 0);
    vecs[1] = 32'h7F800000; exps[1] = pack(2, 31, 31, 0, 1, 0, 0);
    vecs[2] = 32'hFFC00000; exps[2] = pack(2, 0, 0, 0, 0, 1, 0);
    vecs[3] = 32'h7FC00000; exps[3] = pack(2, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      run_conv(vecs[i], obs);
      tests++;
      if (obs !== exps[i]) begin
        fails++;
        $display("FAIL special[%0h]: got %h want %h", vecs[i], obs, exps[i]);
      end
    end
  endtask

  task automatic test_small;
    logic [21:0] obs;
    logic [31:0] vecs [4];
    logic [21:0] exps [4];
    vecs[0] = 32'h00000000; exps[0] = pack(2, 0, 0, 0, 0, 0, 0);
    vecs[1] = 32'h3C000000; exps[1] = pack(2, 0, 0, 0, 0, 0, 1);
    vecs[2] = 32'h00000005; exps[2] = pack(2, 0, 0, 0, 0, 0, 1);
    vecs[3] = 32'h3D000000; exps[3] = pack(25, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      run_conv(vecs[i], obs);
      tests++;
      if (obs !== exps[i]) begin
        fails++;
        $display("FAIL small[%0h]: got %h want %h", vecs[i], obs, exps[i]);
      end
    end
  endtask

  // Second start while busy is ignored; outputs hold the previous 1/32 result.
  task automatic test_back_to_back;
    logic [21:0] obs;
    int lat;
    lat = 0;
    @(negedge clk);
    fin   = 32'h40D80000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL busy_after_start: got %b want 1", busy);
    end
    repeat (3) begin
      @(posedge clk);
      #1;
      lat++;
    end
    fin   = 32'h42000000;
    start = 1'b1;
    @(posedge clk);
    #1;
    lat++;
    start = 1'b0;
    obs = pack(0, int_part, frac_part, neg, ovf, nan, inexact);
    tests++;
    if (obs !== pack(0, 0, 1, 0, 0, 0, 0) || done !== 1'b0) begin
      fails++;
      $display("FAIL hold_while_busy: got %h done=%b want %h", obs, done, pack(0, 0, 1, 0, 0, 0, 0));
    end
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!done && lat < 40);
    obs = pack(lat, int_part, frac_part, neg, ovf, nan, inexact);
    tests++;
    if (obs !== pack(18, 6, 24, 0, 0, 0, 0) || busy !== 1'b0) begin
      fails++;
      $display("FAIL ignored_start: got %h busy=%b want %h", obs, busy, pack(18, 6, 24, 0, 0, 0, 0));
    end
    run_conv(32'h3F800001, obs);
    tests++;
    if (obs !== pack(20, 1, 0, 0, 0, 0, 1)) begin
      fails++;
      $display("FAIL restart_after_done: got %h want %h", obs, pack(20, 1, 0, 0, 0, 0, 1));
    end
  endtask

  task automatic test_reset_mid_shift;
    logic [21:0] obs;
    int seen;
    @(negedge clk);
    fin   = 32'h40D80000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    obs = pack(0, int_part, frac_part, neg, ovf, nan, inexact);
    tests++;
    if (obs !== 22'd0 || busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL async_clear: got %h busy=%b done=%b want 0", obs, busy, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    tests++;
    if (seen != 0) begin
      fails++;
      $display("FAIL no_done_after_abort: got %0d active cycles want 0", seen);
    end
    run_conv(32'h40D80000, obs);
    tests++;
    if (obs !== pack(18, 6, 24, 0, 0, 0, 0)) begin
      fails++;
      $display("FAIL post_reset_conv: got %h want %h", obs, pack(18, 6, 24, 0, 0, 0, 0));
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_special();
    test_small();
    test_back_to_back();
    test_reset_mid_shift();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
